entropy_collector: RTL and testbench

//  Consumer end of the entropy source syn/data/ack interface. Accepts 32-bit words from one

---
 rtl/entropy_collector_pkg.sv | 18 +
 rtl/entropy_collector_if.sv | 33 +++
 rtl/entropy_rep_test.sv | 57 +++++
 rtl/entropy_collector.sv | 129 ++++++++++++
 tb/tb_entropy_collector.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/entropy_collector_pkg.sv
// Shared trng definitions: entropy word width, collector FSM encoding and block slot helper.
package entropy_collector_pkg;

  localparam int unsigned EntropyWidth = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StAck     = 2'd2,
    StFull    = 2'd3
  } collector_state_e;

  // Word 0 lives in the MSBs of the packed block.
  function automatic int unsigned slot_lsb(input int unsigned num_words, input int unsigned slot);
    return (num_words - 1 - slot) * EntropyWidth;
  endfunction

endpackage

// File: rtl/entropy_collector_if.sv
// Entropy source word handshake and mixer block handshake as seen by one collector.
interface entropy_collector_if #(
  parameter int unsigned NUM_WORDS = 16
);
  localparam int unsigned WordW  = entropy_collector_pkg::EntropyWidth;
  localparam int unsigned BlockW = NUM_WORDS * WordW;

  logic              entropy_syn;
  logic [WordW-1:0]  entropy_data;
  logic              entropy_ack;
  logic              block_syn;
  logic [BlockW-1:0] block_data;
  logic              block_ack;

  modport slave (
    input  entropy_syn,
    input  entropy_data,
    input  block_ack,
    output entropy_ack,
    output block_syn,
    output block_data
  );

  modport master (
    output entropy_syn,
    output entropy_data,
    output block_ack,
    input  entropy_ack,
    input  block_syn,
    input  block_data
  );

endinterface

// File: rtl/entropy_rep_test.sv
// Repetition-count health test over accepted entropy words; fail_o is a registered pulse.
module entropy_rep_test
  import entropy_collector_pkg::*;
#(
  parameter int unsigned REP_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  input  logic                    accept_i,
  input  logic [EntropyWidth-1:0] data_i,
  output logic                    fail_o
);

  logic [EntropyWidth-1:0] last_q, last_d;
  logic [31:0]             ctr_q, ctr_d;
  logic                    fail_q, fail_d;
  logic [31:0]             ctr_inc;
  logic [31:0]             ctr_new;
  logic                    hit;

  always_comb begin
    ctr_inc = (ctr_q == 32'hffff_ffff) ? ctr_q : ctr_q + 32'd1;
    ctr_new = (data_i == last_q) ? ctr_inc : 32'd1;
    hit     = (REP_LIMIT != 0) && (ctr_new >= 32'(REP_LIMIT));
  end

  always_comb begin
    last_d = last_q;
    ctr_d  = ctr_q;
    fail_d = 1'b0;
    if (clear_i) begin
      // A zero count makes the first word after a clear start at 1 whatever its value.
      last_d = '0;
      ctr_d  = '0;
    end else if (accept_i) begin
      last_d = data_i;
      ctr_d  = hit ? 32'd1 : ctr_new;
      fail_d = hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
      ctr_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      last_q <= last_d;
      ctr_q  <= ctr_d;
      fail_q <= fail_d;
    end
  end

  assign fail_o = fail_q;

endmodule

// File: rtl/entropy_collector.sv
// Collects entropy words from one source, health-tests them and offers packed blocks to the mixer.
module entropy_collector
  import entropy_collector_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned REP_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        entropy_enabled,
  entropy_collector_if.slave bus,
  output logic        rep_error,
  output logic [31:0] words_accepted,
  output logic [31:0] rep_errors
);

  localparam int unsigned BlockW = NUM_WORDS * EntropyWidth;
  localparam int unsigned CtrW   = $clog2(NUM_WORDS);

  collector_state_e  state_q, state_d;
  logic [CtrW-1:0]   word_ctr_q, word_ctr_d;
  logic              ack_q, ack_d;
  logic              block_syn_q, block_syn_d;
  logic [BlockW-1:0] block_q, block_d;
  logic [31:0]       words_q, words_d;
  logic [31:0]       errs_q, errs_d;

  logic run;
  logic accept;
  logic rep_clear;
  logic rep_fail;

  assign run       = enable & entropy_enabled;
  assign accept    = (state_q == StCollect) & run & bus.entropy_syn;
  assign rep_clear = (state_q == StIdle);

  entropy_rep_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rep_test (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (rep_clear),
    .accept_i(accept),
    .data_i  (bus.entropy_data),
    .fail_o  (rep_fail)
  );

  always_comb begin
    state_d     = state_q;
    word_ctr_d  = word_ctr_q;
    ack_d       = 1'b0;
    block_syn_d = block_syn_q;
    block_d     = block_q;
    words_d     = words_q;
    errs_d      = errs_q;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d    = StCollect;
          word_ctr_d = '0;
        end
      end
      StCollect: begin
        if (!run) begin
          state_d = StIdle;
        end else if (bus.entropy_syn) begin
          block_d[slot_lsb(NUM_WORDS, 32'(word_ctr_q)) +: EntropyWidth] = bus.entropy_data;
          ack_d   = 1'b1;
          words_d = words_q + 32'd1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (rep_fail) begin
          errs_d     = (errs_q == 32'hffff_ffff) ? errs_q : errs_q + 32'd1;
          word_ctr_d = '0;
          state_d    = StCollect;
        end else if (word_ctr_q == CtrW'(NUM_WORDS - 1)) begin
          block_syn_d = 1'b1;
          state_d     = StFull;
        end else begin
          word_ctr_d = word_ctr_q + 1'b1;
          state_d    = run ? StCollect : StIdle;
        end
      end
      StFull: begin
        // A block_ack in the same cycle as run dropping still consumes the block.
        if (bus.block_ack) begin
          block_syn_d = 1'b0;
          word_ctr_d  = '0;
          state_d     = run ? StCollect : StIdle;
        end else if (!run) begin
          block_syn_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      word_ctr_q  <= '0;
      ack_q       <= 1'b0;
      block_syn_q <= 1'b0;
      block_q     <= '0;
      words_q     <= '0;
      errs_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_ctr_q  <= word_ctr_d;
      ack_q       <= ack_d;
      block_syn_q <= block_syn_d;
      block_q     <= block_d;
      words_q     <= words_d;
      errs_q      <= errs_d;
    end
  end

  assign bus.entropy_ack = ack_q;
  assign bus.block_syn   = block_syn_q;
  assign bus.block_data  = block_q;
  assign rep_error       = rep_fail;
  assign words_accepted  = words_q;
  assign rep_errors      = errs_q;

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector: dut_a (REP_LIMIT=3) and dut_b (REP_LIMIT=0), 4-word blocks.
module tb_entropy_collector;

  localparam int unsigned NW = 4;
  localparam int unsigned BW = NW * 32;

  logic clk = 1'b0;
  logic reset_n;
  logic en_a, en_b, src_en;
  logic syn;
  logic [31:0] data;
  logic back_a, back_b;
  logic rep_a, rep_b;
  logic [31:0] wa_a, re_a, wa_b, re_b;

  int n_pass = 0;
  int n_total = 0;
  logic [BW-1:0] sb_q[$];

  always #5 clk = ~clk;

  entropy_collector_if #(.NUM_WORDS(NW)) if_a ();
  entropy_collector_if #(.NUM_WORDS(NW)) if_b ();

  assign if_a.entropy_syn  = syn;
  assign if_a.entropy_data = data;
  assign if_a.block_ack    = back_a;
  assign if_b.entropy_syn  = syn;
  assign if_b.entropy_data = data;
  assign if_b.block_ack    = back_b;

  entropy_collector #(.NUM_WORDS(NW), .REP_LIMIT(3)) dut_a (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (en_a),
    .entropy_enabled(src_en),
    .bus            (if_a.slave),
    .rep_error      (rep_a),
    .words_accepted (wa_a),
    .rep_errors     (re_a)
  );

  entropy_collector #(.NUM_WORDS(NW), .REP_LIMIT(0)) dut_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (en_b),
    .entropy_enabled(src_en),
    .bus            (if_b.slave),
    .rep_error      (rep_b),
    .words_accepted (wa_b),
    .rep_errors     (re_b)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one word and return at the negedge where the ack is visible.
  task automatic send(input bit sel, input logic [31:0] w, output logic rep);
    logic got;
    got  = 1'b0;
    rep  = 1'b0;
    data = w;
    syn  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? if_b.entropy_ack : if_a.entropy_ack) === 1'b1) begin
        got = 1'b1;
        rep = sel ? rep_b : rep_a;
        break;
      end
    end
    syn = 1'b0;
    check("ack_seen", got, 1'b1);
  endtask

  task automatic send_block(input bit sel, input logic [31:0] base, input logic [31:0] step);
    logic [BW-1:0] exp;
    logic rep;
    exp = '0;
    for (int i = 0; i < NW; i++) begin
      exp = {exp[BW-33:0], base + step * 32'(i)};
      send(sel, base + step * 32'(i), rep);
      check("no_rep_error", rep, 1'b0);
    end
    sb_q.push_back(exp);
  endtask

  task automatic take_block(input bit sel);
    logic seen;
    logic [BW-1:0] exp;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? if_b.block_syn : if_a.block_syn) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("block_syn_seen", seen, 1'b1);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 1'b0, 1'b1);
    end else begin
      exp = sb_q.pop_front();
      check("block_data", sel ? if_b.block_data : if_a.block_data, exp);
    end
    if (sel) back_b = 1'b1;
    else back_a = 1'b1;
    @(negedge clk);
    back_a = 1'b0;
    back_b = 1'b0;
    check("block_syn_clr", sel ? if_b.block_syn : if_a.block_syn, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] frozen;
    logic [31:0] w;
    logic rep;
    reset_n = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    src_en  = 1'b1;
    syn     = 1'b0;
    data    = '0;
    back_a  = 1'b0;
    back_b  = 1'b0;

    // Reset state.
    #12;
    check("rst_ack", if_a.entropy_ack, 1'b0);
    check("rst_block_syn", if_a.block_syn, 1'b0);
    check("rst_block_data", if_a.block_data, '0);
    check("rst_words", wa_a, 32'd0);
    check("rst_reps", re_a, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Exact handshake timing: words 1..4 with syn held high.
    en_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back({32'd1, 32'd2, 32'd3, 32'd4});
    w    = 32'd1;
    data = w;
    syn  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("t2_ack_c%0d", i), if_a.entropy_ack, ((i % 2) == 1) && (i <= 7));
      check($sformatf("t2_bsyn_c%0d", i), if_a.block_syn, i == 8);
      if (if_a.entropy_ack === 1'b1) begin
        w    = (w == 32'd4) ? 32'd5 : w + 32'd1;
        data = w;
      end
    end
    frozen = sb_q.pop_front();
    check("t2_block_data", if_a.block_data, frozen);
    check("t2_words", wa_a, 32'd4);

    // Stall in FULL with syn high: no acks, data frozen.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_no_ack", if_a.entropy_ack, 1'b0);
      check("t3_frozen", if_a.block_data, frozen);
    end
    back_a = 1'b1;
    @(negedge clk);
    back_a = 1'b0;
    check("t3_bsyn_clr", if_a.block_syn, 1'b0);
    @(negedge clk);
    check("t3_resume_ack", if_a.entropy_ack, 1'b1);
    syn = 1'b0;
    sb_q.push_back({32'd5, 32'd6, 32'd7, 32'd8});
    for (int i = 6; i <= 8; i++) begin
      send(1'b0, 32'(i), rep);
      check("t3_no_rep", rep, 1'b0);
    end
    take_block(1'b0);
    check("t3_words", wa_a, 32'd8);

    // Reset mid-block.
    send(1'b0, 32'h9, rep);
    send(1'b0, 32'ha, rep);
    #2 reset_n = 1'b0;
    #1;
    check("t1_ack", if_a.entropy_ack, 1'b0);
    check("t1_bsyn", if_a.block_syn, 1'b0);
    check("t1_data", if_a.block_data, '0);
    check("t1_words", wa_a, 32'd0);
    check("t1_rep", rep_a, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    send_block(1'b0, 32'h100, 32'd1);
    take_block(1'b0);
    check("t1_words_after", wa_a, 32'd4);

    // Drop enable while in ACK.
    send(1'b0, 32'h200, rep);
    en_a = 1'b0;
    syn  = 1'b1;
    data = 32'h201;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5a_no_ack", if_a.entropy_ack, 1'b0);
      check("t5a_bsyn", if_a.block_syn, 1'b0);
    end
    check("t5a_words", wa_a, 32'd5);

    // Drop enable while in FULL: block discarded.
    syn  = 1'b0;
    en_a = 1'b1;
    for (int i = 0; i < NW; i++) send(1'b0, 32'h300 + 32'(i), rep);
    @(negedge clk);
    check("t5b_full", if_a.block_syn, 1'b1);
    en_a = 1'b0;
    @(negedge clk);
    check("t5b_bsyn_clr", if_a.block_syn, 1'b0);
    syn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5b_no_ack", if_a.entropy_ack, 1'b0);
    end
    syn = 1'b0;
    check("t5b_words", wa_a, 32'd9);

    // Constant data with REP_LIMIT=3: failures on the 3rd, 5th, 7th, 9th words.
    en_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      send(1'b0, 32'ha5a5_a5a5, rep);
      check($sformatf("t4_rep_w%0d", k), rep, (k >= 3) && ((k % 2) == 1));
      check("t4_no_block", if_a.block_syn, 1'b0);
    end
    @(negedge clk);
    check("t4_rep_pulse_end", rep_a, 1'b0);
    check("t4_errs", re_a, 32'd4);
    check("t4_words", wa_a, 32'd18);
    en_a = 1'b0;

    // REP_LIMIT=0: constant-data blocks flow and no health failures.
    en_b = 1'b1;
    for (int b = 0; b < 2; b++) begin
      send_block(1'b1, 32'ha5a5_a5a5, 32'd0);
      take_block(1'b1);
    end
    check("t6_errs", re_b, 32'd0);
    check("t6_words", wa_b, 32'd8);
    check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
